// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-bank command decoder.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        WAIT_DUMMY
    } state_t;

    localparam int         CMD_WR_BIT   = 7;
    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_frame_timeout.sv
// Frame-gap watchdog: counts cycles while enabled and flags expiry on the
// last allowed cycle; saturates there until cleared.
module spi_frame_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/spi_reg_bank.sv
// Two-frame SPI register-bank decoder (command byte, then data/dummy byte).
// Define SPI_REG_WR_ECHO_EN to return the written byte in the following frame.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int RO_BASE     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                               sys_clk,
    input  logic                               rst_n,
    input  logic [7:0]                         rxd_data,
    input  logic                               rxd_flag,
    input  logic [(2**ADDR_W-RO_BASE)*8-1:0]   status_in,
    output logic [7:0]                         txd_data,
    output logic [RO_BASE*8-1:0]               ctrl_regs,
    output logic                               wr_strobe,
    output logic [ADDR_W-1:0]                  wr_addr,
    output logic                               err_pulse
);

    localparam int              ST_N      = 2**ADDR_W - RO_BASE;
    localparam logic [ADDR_W:0] RO_BASE_W = (ADDR_W+1)'(RO_BASE);
    localparam logic [7:0]      RSV_MASK  = 8'h7F & ~8'((1 << ADDR_W) - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        ctrl_q [RO_BASE];
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rsv;
    logic              addr_is_ctrl;
    logic              tmo_clear;
    logic              tmo_enable;
    logic              tmo_expire;

    assign cmd_addr     = rxd_data[ADDR_W-1:0];
    assign cmd_rsv      = |(rxd_data & RSV_MASK);
    assign addr_is_ctrl = ({1'b0, addr_q} < RO_BASE_W);
    assign tmo_clear    = (state == IDLE) && rxd_flag;
    assign tmo_enable   = (state != IDLE);

    // Readback source for a read command, addressed straight from the command byte.
    always_comb begin
        rd_byte = TX_IDLE_BYTE;
        for (int k = 0; k < RO_BASE; k++) begin
            if (cmd_addr == ADDR_W'(k)) rd_byte = ctrl_q[k];
        end
        for (int k = 0; k < ST_N; k++) begin
            if (cmd_addr == ADDR_W'(RO_BASE + k)) rd_byte = status_in[8*k +: 8];
        end
    end

    for (genvar g = 0; g < RO_BASE; g++) begin : g_ctrl_out
        assign ctrl_regs[8*g +: 8] = ctrl_q[g];
    end

    spi_frame_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expire  (tmo_expire)
    );

    // A received byte always takes priority over a coinciding timeout expiry.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            txd_data  <= TX_IDLE_BYTE;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err_pulse <= 1'b0;
            for (int k = 0; k < RO_BASE; k++) ctrl_q[k] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxd_flag) begin
`ifdef SPI_REG_WR_ECHO_EN
                        txd_data <= TX_IDLE_BYTE;
`endif
                        if (cmd_rsv) begin
                            err_pulse <= 1'b1;
                        end else begin
                            addr_q <= cmd_addr;
                            if (rxd_data[CMD_WR_BIT]) begin
                                state <= WAIT_DATA;
                            end else begin
                                txd_data <= rd_byte;
                                state    <= WAIT_DUMMY;
                            end
                        end
                    end
                end
                WAIT_DATA: begin
                    if (rxd_flag) begin
                        if (addr_is_ctrl) begin
                            for (int k = 0; k < RO_BASE; k++) begin
                                if (addr_q == ADDR_W'(k)) ctrl_q[k] <= rxd_data;
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr_q;
`ifdef SPI_REG_WR_ECHO_EN
                            txd_data  <= rxd_data;
`endif
                        end else begin
                            err_pulse <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (tmo_expire) begin
                        err_pulse <= 1'b1;
                        txd_data  <= TX_IDLE_BYTE;
                        state     <= IDLE;
                    end
                end
                WAIT_DUMMY: begin
                    if (rxd_flag) begin
                        txd_data <= TX_IDLE_BYTE;
                        state    <= IDLE;
                    end else if (tmo_expire) begin
                        err_pulse <= 1'b1;
                        txd_data  <= TX_IDLE_BYTE;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: transaction-level reference model plus
// directed protocol cases and randomized byte streams.
module tb_spi_reg_bank;

    localparam int ADDR_W      = 4;
    localparam int RO_BASE     = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int ST_W        = (2**ADDR_W - RO_BASE) * 8;

`ifdef SPI_REG_WR_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_WR   = 2'd1;
    localparam logic [1:0] P_RD   = 2'd2;

    logic              sys_clk   = 1'b0;
    logic              rst_n     = 1'b0;
    logic [7:0]        rxd_data  = 8'h00;
    logic              rxd_flag  = 1'b0;
    logic [ST_W-1:0]   status_in = '0;
    logic [7:0]        txd_data;
    logic [RO_BASE*8-1:0] ctrl_regs;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic              err_pulse;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    bit cmp_on = 1'b0;
    logic [7:0] rnd_byte;
    int         rnd_gap;

    spi_reg_bank #(
        .ADDR_W      (ADDR_W),
        .RO_BASE     (RO_BASE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .rxd_data  (rxd_data),
        .rxd_flag  (rxd_flag),
        .status_in (status_in),
        .txd_data  (txd_data),
        .ctrl_regs (ctrl_regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_pulse (err_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0]  pend;
        logic [3:0]  addr;
        int          entry;
        logic [63:0] ctrl;
        logic [7:0]  txd;
        logic        wr;
        logic [3:0]  wr_addr;
        logic        err;
    } model_t;

    model_t m;

    // One clock of the protocol: a pending transaction either completes on a byte,
    // or is abandoned once TIMEOUT_CYC cycles have elapsed since its command.
    function automatic model_t modelStep(model_t s, logic flag, logic [7:0] d,
                                         logic [63:0] st, int now);
        model_t n;
        int a;
        int pa;
        n     = s;
        n.wr  = 1'b0;
        n.err = 1'b0;
        a     = int'(d[3:0]);
        pa    = int'(s.addr);
        if (s.pend == P_NONE) begin
            if (flag) begin
                n.txd = 8'h00;
                if (d[6:4] != 3'b000) begin
                    n.err = 1'b1;
                end else begin
                    n.addr  = d[3:0];
                    n.entry = now;
                    if (d[7]) begin
                        n.pend = P_WR;
                    end else begin
                        n.pend = P_RD;
                        n.txd  = (a < RO_BASE) ? s.ctrl[a*8 +: 8] : st[(a-RO_BASE)*8 +: 8];
                    end
                end
            end
        end else if (flag) begin
            if (s.pend == P_WR) begin
                if (pa < RO_BASE) begin
                    n.ctrl[pa*8 +: 8] = d;
                    n.wr      = 1'b1;
                    n.wr_addr = s.addr;
                    n.txd     = ECHO ? d : 8'h00;
                end else begin
                    n.err = 1'b1;
                end
            end else begin
                n.txd = 8'h00;
            end
            n.pend = P_NONE;
        end else if (now - s.entry == TIMEOUT_CYC) begin
            n.pend = P_NONE;
            n.err  = 1'b1;
            n.txd  = 8'h00;
        end
        return n;
    endfunction

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= modelStep(m, rxd_flag, rxd_data, status_in, cyc);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (cmp_on) begin
            checkOutput("txd_data",  64'(txd_data),  64'(m.txd));
            checkOutput("ctrl_regs", 64'(ctrl_regs), m.ctrl);
            checkOutput("wr_strobe", 64'(wr_strobe), 64'(m.wr));
            checkOutput("wr_addr",   64'(wr_addr),   64'(m.wr_addr));
            checkOutput("err_pulse", 64'(err_pulse), 64'(m.err));
        end
    end

    // Entered and left 1 time unit after a rising edge; pulses one byte then idles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rxd_data = b;
        rxd_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        rxd_flag = 1'b0;
        rxd_data = 8'($urandom);
        repeat (gap) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    initial begin
        status_in        = {$urandom, $urandom};
        status_in[15:8]  = 8'hC3;
        repeat (3) @(posedge sys_clk);
        #1;
        cmp_on = 1'b1;

        checkOutput("reset_txd",  64'(txd_data),  64'h00);
        checkOutput("reset_ctrl", 64'(ctrl_regs), 64'h0);
        checkOutput("reset_wr",   64'(wr_strobe), 64'h0);
        checkOutput("reset_waddr",64'(wr_addr),   64'h0);
        checkOutput("reset_err",  64'(err_pulse), 64'h0);
        rst_n = 1'b1;
        idleCycles(1);

        // Write then read back.
        applyStimulus(8'h83, 0);
        applyStimulus(8'h5A, 0);
        checkOutput("wr3_strobe", 64'(wr_strobe), 64'h1);
        checkOutput("wr3_addr",   64'(wr_addr),   64'h3);
        checkOutput("wr3_ctrl",   64'(ctrl_regs[31:24]), 64'h5A);
        checkOutput("model_ctrl3",64'(m.ctrl[31:24]),    64'h5A);
        idleCycles(1);
        checkOutput("wr3_strobe_end", 64'(wr_strobe), 64'h0);
        applyStimulus(8'h03, 0);
        checkOutput("rd3_txd", 64'(txd_data), 64'h5A);
        applyStimulus(8'hFF, 0);
        checkOutput("dummy_txd", 64'(txd_data), 64'h00);

        // Status read and write to a read-only address.
        applyStimulus(8'h09, 0);
        checkOutput("rd9_txd", 64'(txd_data), 64'hC3);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h89, 0);
        applyStimulus(8'h11, 0);
        checkOutput("ro_wr_err",    64'(err_pulse), 64'h1);
        checkOutput("ro_wr_strobe", 64'(wr_strobe), 64'h0);
        checkOutput("ro_wr_ctrl",   64'(ctrl_regs), 64'h00000000_5A000000);

        // Reserved bits rejected, following write still accepted.
        applyStimulus(8'h13, 0);
        checkOutput("rsv_err", 64'(err_pulse), 64'h1);
        applyStimulus(8'h81, 0);
        applyStimulus(8'h22, 0);
        checkOutput("wr1_ctrl", 64'(ctrl_regs[15:8]), 64'h22);
        checkOutput("wr1_addr", 64'(wr_addr), 64'h1);
        applyStimulus(8'h84, 0);
        applyStimulus(8'h77, 2);

        // Timeout: err_pulse only after TIMEOUT_CYC idle cycles in the wait state.
        applyStimulus(8'h82, 0);
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            idleCycles(1);
            checkOutput("tmo_early_err", 64'(err_pulse), 64'h0);
        end
        idleCycles(1);
        checkOutput("tmo_err", 64'(err_pulse), 64'h1);
        applyStimulus(8'h44, 0);
        checkOutput("tmo_next_is_cmd_err", 64'(err_pulse), 64'h1);
        checkOutput("tmo_next_no_write",   64'(ctrl_regs[23:16]), 64'h00);
        applyStimulus(8'h04, 0);
        checkOutput("rd4_txd", 64'(txd_data), 64'h77);
        applyStimulus(8'h00, 0);

        // Byte arriving on the expiry cycle completes the write.
        applyStimulus(8'h86, 0);
        idleCycles(TIMEOUT_CYC - 1);
        applyStimulus(8'hA5, 0);
        checkOutput("race_wr",   64'(wr_strobe), 64'h1);
        checkOutput("race_err",  64'(err_pulse), 64'h0);
        checkOutput("race_ctrl", 64'(ctrl_regs[55:48]), 64'hA5);

        // Write echo.
        applyStimulus(8'h85, 0);
        applyStimulus(8'h3C, 0);
        checkOutput("echo_wr", 64'(wr_strobe), 64'h1);
        checkOutput("echo_txd", 64'(txd_data), ECHO ? 64'h3C : 64'h00);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);

        // Reset in the middle of a write transaction.
        applyStimulus(8'h87, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("rst_mid_ctrl", 64'(ctrl_regs), 64'h0);
        checkOutput("rst_mid_txd",  64'(txd_data),  64'h0);
        checkOutput("rst_mid_err",  64'(err_pulse), 64'h0);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'h99, 0);
        checkOutput("rst_mid_no_write", 64'(ctrl_regs), 64'h0);
        checkOutput("rst_mid_wr",       64'(wr_strobe), 64'h0);

        // Randomized byte streams with occasional long gaps and expiry races.
        for (int i = 0; i < 400; i++) begin
            rnd_byte = 8'($urandom);
            if ($urandom_range(0, 9) < 8) rnd_byte = rnd_byte & 8'h8F;
            case ($urandom_range(0, 9))
                0:       rnd_gap = TIMEOUT_CYC + 2;
                1:       rnd_gap = TIMEOUT_CYC - 1;
                default: rnd_gap = $urandom_range(0, 2);
            endcase
            if ($urandom_range(0, 15) == 0) status_in = {$urandom, $urandom};
            applyStimulus(rnd_byte, rnd_gap);
        end

        idleCycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
